// File: rtl/shift_ctrl.sv
// Multi-cycle 16-bit shifter/rotator with valid/ready handshakes on both sides.
// A request is captured in IDLE, shifted by at most two bit positions per cycle
// in SHIFT, and then held in DONE until the consumer takes the result.
module shift_ctrl #(
    parameter logic [1:0] OP_ROL = 2'd0,
    parameter logic [1:0] OP_SLL = 2'd1,
    parameter logic [1:0] OP_ROR = 2'd2,
    parameter logic [1:0] OP_ASR = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_op,
    input  logic [3:0]  in_cnt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] work_q,  work_d;
    logic [1:0]  op_q,    op_d;
    logic [3:0]  rem_q,   rem_d;

    // Held low through reset so in_ready only appears after the first clock
    // edge that follows reset release.
    logic        readyEn_q;

    logic        stepTwo;
    logic [3:0]  stepSize;
    logic [15:0] stepResult;

    // Registers all state; reset aborts any operation in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= 16'h0000;
            op_q      <= 2'd0;
            rem_q     <= 4'd0;
            readyEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            readyEn_q <= 1'b1;
        end
    end

    // One shift step of the working register: two positions while at least two
    // remain, otherwise one, using the operation captured at acceptance.
    always_comb begin
        stepTwo    = (rem_q >= 4'd2);
        stepSize   = stepTwo ? 4'd2 : 4'd1;
        stepResult = work_q;
        case (op_q)
            OP_ROL:  stepResult = stepTwo ? {work_q[13:0], work_q[15:14]}
                                          : {work_q[14:0], work_q[15]};
            OP_SLL:  stepResult = stepTwo ? {work_q[13:0], 2'b00}
                                          : {work_q[14:0], 1'b0};
            OP_ROR:  stepResult = stepTwo ? {work_q[1:0], work_q[15:2]}
                                          : {work_q[0], work_q[15:1]};
            OP_ASR:  stepResult = stepTwo ? {{2{work_q[15]}}, work_q[15:2]}
                                          : {work_q[15], work_q[15:1]};
            default: stepResult = work_q;
        endcase
    end

    // Next-state logic: capture on acceptance, step until the remaining count
    // is exhausted, then wait for the consumer before returning to IDLE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_d  = in_data;
                    op_d    = in_op;
                    rem_d   = in_cnt;
                    state_d = (in_cnt == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d  = stepResult;
                rem_d   = rem_q - stepSize;
                state_d = (rem_d == 4'd0) ? DONE : SHIFT;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && readyEn_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed vectors, randomized operations
// against an arithmetic reference model, back-pressure, mid-operation reset
// and back-to-back requests.
module tb_shift_ctrl;

    localparam logic [1:0] OP_ROL = 2'd0;
    localparam logic [1:0] OP_SLL = 2'd1;
    localparam logic [1:0] OP_ROR = 2'd2;
    localparam logic [1:0] OP_ASR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_op;
    logic [3:0]  in_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int passCount  = 0;
    int checkCount = 0;

    shift_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Reference result: the whole shift done at once with plain arithmetic.
    function automatic logic [15:0] modelResult(input logic [1:0] op, input logic [15:0] data,
                                                input logic [3:0] cnt);
        logic [31:0] dbl;
        logic [31:0] tmp;
        dbl = {data, data};
        case (op)
            OP_ROL: begin tmp = dbl << cnt; return tmp[31:16]; end
            OP_ROR: begin tmp = dbl >> cnt; return tmp[15:0]; end
            OP_SLL: return data << cnt;
            default: return 16'($signed(data) >>> cnt);
        endcase
    endfunction

    // Cycle index at which out_valid is first seen, counting the cycle right
    // after the acceptance edge as 1.
    function automatic int modelLatency(input logic [3:0] cnt);
        return (int'(cnt) + 1) / 2 + 1;
    endfunction

    // Drives one request and waits for the result; inputs are scrambled after
    // acceptance and out_ready is toggled randomly while the shift is running.
    task automatic doTransaction(input logic [1:0] op, input logic [15:0] data, input logic [3:0] cnt,
                                 output logic [15:0] result, output int latency,
                                 output int waitCycles, output bit timedOut);
        timedOut   = 1'b0;
        waitCycles = 0;
        latency    = 0;
        result     = 16'h0000;
        in_valid   = 1'b1;
        in_data    = data;
        in_op      = op;
        in_cnt     = cnt;
        while (!in_ready && waitCycles < 50) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!in_ready) begin
            timedOut = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_op    = 2'($urandom_range(3));
        in_cnt   = 4'($urandom_range(15));
        latency  = 1;
        while (!out_valid && latency < 50) begin
            out_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
            latency++;
        end
        out_ready = 1'b0;
        if (!out_valid) timedOut = 1'b1;
        result = out_data;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_op     = 2'd0;
        in_cnt    = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if ({out_valid, busy, in_ready, out_data} !== 19'd0)
            $display("[TB] FAIL reset_outputs: got valid=%b busy=%b ready=%b data=%h, expected all zero",
                     out_valid, busy, in_ready, out_data);
        else passCount++;
        rst_n = 1'b1;
        #1;
        checkCount++;
        if (in_ready !== 1'b0)
            $display("[TB] FAIL ready_before_edge: got %b expected 0", in_ready);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL ready_after_release: got ready=%b busy=%b expected 1/0", in_ready, busy);
        else passCount++;
    endtask

    task automatic test_directed;
        logic [1:0]  ops  [5] = '{OP_ROL, OP_SLL, OP_ROR, OP_ASR, OP_ROR};
        logic [15:0] datas[5] = '{16'h8001, 16'h00FF, 16'h0001, 16'h8000, 16'hA5A5};
        logic [3:0]  cnts [5] = '{4'd4, 4'd3, 4'd1, 4'd15, 4'd0};
        logic [15:0] exps [5] = '{16'h0018, 16'h07F8, 16'h8000, 16'hFFFF, 16'hA5A5};
        int          lats [5] = '{3, 3, 2, 9, 1};
        logic [15:0] result;
        int          latency, waitCycles;
        bit          timedOut;
        for (int i = 0; i < 5; i++) begin
            doTransaction(ops[i], datas[i], cnts[i], result, latency, waitCycles, timedOut);
            checkCount++;
            if (timedOut || result !== exps[i])
                $display("[TB] FAIL directed_data[%0d]: got %h expected %h (timeout=%0b)", i, result, exps[i], timedOut);
            else passCount++;
            checkCount++;
            if (latency != lats[i])
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, latency, lats[i]);
            else passCount++;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [15:0] data, result;
        logic [3:0]  cnt;
        int          latency, waitCycles;
        bit          timedOut;
        for (int i = 0; i < 30; i++) begin
            op   = 2'($urandom_range(3));
            data = 16'($urandom);
            cnt  = 4'($urandom_range(15));
            doTransaction(op, data, cnt, result, latency, waitCycles, timedOut);
            checkCount++;
            if (timedOut || result !== modelResult(op, data, cnt))
                $display("[TB] FAIL random_data op=%0d cnt=%0d in=%h: got %h expected %h",
                         op, cnt, data, result, modelResult(op, data, cnt));
            else passCount++;
            checkCount++;
            if (latency != modelLatency(cnt))
                $display("[TB] FAIL random_latency cnt=%0d: got %0d expected %0d", cnt, latency, modelLatency(cnt));
            else passCount++;
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] result;
        int          latency, waitCycles;
        bit          timedOut;
        bit          stable = 1'b1;
        doTransaction(OP_ASR, 16'h9234, 4'd5, result, latency, waitCycles, timedOut);
        checkCount++;
        if (timedOut || result !== 16'hFC91)
            $display("[TB] FAIL backpressure_data: got %h expected fc91", result);
        else passCount++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 16'hFC91 || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        checkCount++;
        if (!stable)
            $display("[TB] FAIL backpressure_hold: got valid=%b data=%h ready=%b, expected 1/fc91/0",
                     out_valid, out_data, in_ready);
        else passCount++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkCount++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL backpressure_release: got valid=%b busy=%b ready=%b expected 0/0/1",
                     out_valid, busy, in_ready);
        else passCount++;
    endtask

    task automatic test_reset_midop;
        logic [15:0] result;
        int          latency, waitCycles;
        bit          timedOut;
        bit          sawValid = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_op    = OP_ROL;
        in_cnt   = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({out_valid, busy, in_ready, out_data} !== 19'd0)
            $display("[TB] FAIL midop_reset_outputs: got valid=%b busy=%b ready=%b data=%h, expected all zero",
                     out_valid, busy, in_ready, out_data);
        else passCount++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid)
            $display("[TB] FAIL midop_no_result: got out_valid pulse, expected none");
        else passCount++;
        doTransaction(OP_SLL, 16'h0F0F, 4'd6, result, latency, waitCycles, timedOut);
        checkCount++;
        if (timedOut || result !== 16'hC3C0 || latency != 4)
            $display("[TB] FAIL midop_recovery: got %h lat %0d expected c3c0 lat 4", result, latency);
        else passCount++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0]  op;
        logic [15:0] data, result;
        logic [3:0]  cnt;
        int          latency, waitCycles;
        bit          timedOut;
        for (int i = 0; i < 6; i++) begin
            op   = 2'($urandom_range(3));
            data = 16'($urandom);
            cnt  = 4'($urandom_range(15));
            doTransaction(op, data, cnt, result, latency, waitCycles, timedOut);
            checkCount++;
            if (timedOut || result !== modelResult(op, data, cnt))
                $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, result, modelResult(op, data, cnt));
            else passCount++;
            if (i > 0) begin
                checkCount++;
                if (waitCycles != 0)
                    $display("[TB] FAIL b2b_accept_delay[%0d]: got %0d expected 0", i, waitCycles);
                else passCount++;
            end
            out_ready = 1'b1;
            #1;
            checkCount++;
            if (in_ready !== 1'b0)
                $display("[TB] FAIL b2b_ready_in_done[%0d]: got %b expected 0", i, in_ready);
            else passCount++;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
